// File: rtl/alu_rs_sched.sv
// ALU reservation station scheduler.
// Holds up to RS_DEPTH dispatched ALU instructions. Pending source operands
// snoop the ALU and LSB result buses. Each cycle, the lowest-index slot with
// both operands valid is issued to the ALU through registered outputs.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global stall when low)
//   dispatch_*      : instruction, operand tags/values and ROB entry from decode
//   alu_*, lsb_*    : two result broadcast buses (ALU bus wins on a tag tie)
//   flush           : misprediction rollback, empties every slot
//   rs_full         : combinational, no empty slot at the start of this cycle
//   new_calculate, instruction, op, vj, vk, pc, imm, entry : registered ALU issue
module alu_rs_sched #(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned TAG_W    = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,

    input  logic             dispatch_valid,
    input  logic [5:0]       dispatch_op,
    input  logic [31:0]      dispatch_inst,
    input  logic [31:0]      dispatch_pc,
    input  logic [31:0]      dispatch_imm,
    input  logic [TAG_W-1:0] dispatch_entry,
    input  logic             dispatch_qj_busy,
    input  logic [TAG_W-1:0] dispatch_qj,
    input  logic [31:0]      dispatch_vj,
    input  logic             dispatch_qk_busy,
    input  logic [TAG_W-1:0] dispatch_qk,
    input  logic [31:0]      dispatch_vk,

    input  logic             alu_broadcast,
    input  logic [TAG_W-1:0] alu_entry,
    input  logic [31:0]      alu_result,
    input  logic             lsb_broadcast,
    input  logic [TAG_W-1:0] lsb_entry,
    input  logic [31:0]      lsb_result,

    input  logic             flush,

    output logic             rs_full,

    output logic             new_calculate,
    output logic [31:0]      instruction,
    output logic [5:0]       op,
    output logic [31:0]      vj,
    output logic [31:0]      vk,
    output logic [31:0]      pc,
    output logic [31:0]      imm,
    output logic [TAG_W-1:0] entry
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_WAITING = 2'd1,
        SLOT_READY   = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic            busy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0] val;
    } operand_t;

    typedef struct packed {
        slot_state_e      state;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  inst;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] entry;
        operand_t         j;
        operand_t         k;
    } slot_t;

    typedef struct packed {
        logic [XLEN-1:0]  inst;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] entry;
    } issue_t;

    slot_t            slot_q [RS_DEPTH];
    slot_t            slot_d [RS_DEPTH];
    issue_t           issue_q;
    issue_t           issue_d;
    logic             new_calculate_q;
    logic             new_calculate_d;

    logic             issue_found;
    logic [IDX_W-1:0] issue_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    operand_t         disp_j;
    operand_t         disp_k;

    // Resolve a pending operand against both result buses; ALU bus has priority.
    function automatic operand_t snoop(
        input operand_t         opnd,
        input logic             a_v,
        input logic [TAG_W-1:0] a_tag,
        input logic [XLEN-1:0]  a_val,
        input logic             l_v,
        input logic [TAG_W-1:0] l_tag,
        input logic [XLEN-1:0]  l_val
    );
        operand_t res;
        res = opnd;
        if (opnd.busy) begin
            if (a_v && (a_tag == opnd.tag)) begin
                res.busy = 1'b0;
                res.val  = a_val;
            end else if (l_v && (l_tag == opnd.tag)) begin
                res.busy = 1'b0;
                res.val  = l_val;
            end
        end
        return res;
    endfunction

    // Lowest-index READY slot (issue) and lowest-index EMPTY slot (allocation),
    // both taken from start-of-cycle state so a freed slot is not reused this cycle.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            if (!issue_found && (slot_q[i].state == SLOT_READY)) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!free_found && (slot_q[i].state == SLOT_EMPTY)) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign rs_full = !free_found;

    // Next-state: wakeup, issue and dispatch; flush and stall take precedence.
    always_comb begin
        slot_d          = slot_q;
        issue_d         = issue_q;
        new_calculate_d = 1'b0;

        disp_j = snoop('{busy: dispatch_qj_busy, tag: dispatch_qj, val: dispatch_vj},
                       alu_broadcast, alu_entry, alu_result,
                       lsb_broadcast, lsb_entry, lsb_result);
        disp_k = snoop('{busy: dispatch_qk_busy, tag: dispatch_qk, val: dispatch_vk},
                       alu_broadcast, alu_entry, alu_result,
                       lsb_broadcast, lsb_entry, lsb_result);

        if (rdy_in) begin
            if (flush) begin
                for (int i = 0; i < int'(RS_DEPTH); i++) begin
                    slot_d[i].state = SLOT_EMPTY;
                end
            end else begin
                // A slot becoming READY here is only issue-eligible next cycle.
                for (int i = 0; i < int'(RS_DEPTH); i++) begin
                    if (slot_q[i].state == SLOT_WAITING) begin
                        slot_d[i].j = snoop(slot_q[i].j, alu_broadcast, alu_entry, alu_result,
                                            lsb_broadcast, lsb_entry, lsb_result);
                        slot_d[i].k = snoop(slot_q[i].k, alu_broadcast, alu_entry, alu_result,
                                            lsb_broadcast, lsb_entry, lsb_result);
                        if (!slot_d[i].j.busy && !slot_d[i].k.busy) begin
                            slot_d[i].state = SLOT_READY;
                        end
                    end
                end

                if (issue_found) begin
                    issue_d.inst    = slot_q[issue_idx].inst;
                    issue_d.op      = slot_q[issue_idx].op;
                    issue_d.vj      = slot_q[issue_idx].j.val;
                    issue_d.vk      = slot_q[issue_idx].k.val;
                    issue_d.pc      = slot_q[issue_idx].pc;
                    issue_d.imm     = slot_q[issue_idx].imm;
                    issue_d.entry   = slot_q[issue_idx].entry;
                    new_calculate_d = 1'b1;
                    slot_d[issue_idx].state = SLOT_EMPTY;
                end

                if (dispatch_valid && free_found) begin
                    slot_d[free_idx].state = (disp_j.busy || disp_k.busy) ? SLOT_WAITING
                                                                          : SLOT_READY;
                    slot_d[free_idx].op    = dispatch_op;
                    slot_d[free_idx].inst  = dispatch_inst;
                    slot_d[free_idx].pc    = dispatch_pc;
                    slot_d[free_idx].imm   = dispatch_imm;
                    slot_d[free_idx].entry = dispatch_entry;
                    slot_d[free_idx].j     = disp_j;
                    slot_d[free_idx].k     = disp_k;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                slot_q[i] <= '0;
            end
            issue_q         <= '0;
            new_calculate_q <= 1'b0;
        end else begin
            slot_q          <= slot_d;
            issue_q         <= issue_d;
            new_calculate_q <= new_calculate_d;
        end
    end

    assign new_calculate = new_calculate_q;
    assign instruction   = issue_q.inst;
    assign op            = issue_q.op;
    assign vj            = issue_q.vj;
    assign vk            = issue_q.vk;
    assign pc            = issue_q.pc;
    assign imm           = issue_q.imm;
    assign entry         = issue_q.entry;

endmodule

// File: tb/tb_alu_rs_sched.sv
// Self-checking bench for alu_rs_sched: directed scenarios followed by random
// traffic, every cycle compared against a slot-list reference model.
module tb_alu_rs_sched;

    localparam int RS = 8;
    localparam int TW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, flush;
    logic          dispatch_valid;
    logic [5:0]    dispatch_op;
    logic [31:0]   dispatch_inst, dispatch_pc, dispatch_imm;
    logic [TW-1:0] dispatch_entry;
    logic          dispatch_qj_busy, dispatch_qk_busy;
    logic [TW-1:0] dispatch_qj, dispatch_qk;
    logic [31:0]   dispatch_vj, dispatch_vk;
    logic          alu_broadcast, lsb_broadcast;
    logic [TW-1:0] alu_entry, lsb_entry;
    logic [31:0]   alu_result, lsb_result;
    logic          rs_full, new_calculate;
    logic [31:0]   instruction, vj, vk, pc, imm;
    logic [5:0]    op;
    logic [TW-1:0] entry;

    alu_rs_sched #(.RS_DEPTH(RS), .TAG_W(TW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
        .dispatch_inst(dispatch_inst), .dispatch_pc(dispatch_pc),
        .dispatch_imm(dispatch_imm), .dispatch_entry(dispatch_entry),
        .dispatch_qj_busy(dispatch_qj_busy), .dispatch_qj(dispatch_qj),
        .dispatch_vj(dispatch_vj), .dispatch_qk_busy(dispatch_qk_busy),
        .dispatch_qk(dispatch_qk), .dispatch_vk(dispatch_vk),
        .alu_broadcast(alu_broadcast), .alu_entry(alu_entry), .alu_result(alu_result),
        .lsb_broadcast(lsb_broadcast), .lsb_entry(lsb_entry), .lsb_result(lsb_result),
        .flush(flush), .rs_full(rs_full),
        .new_calculate(new_calculate), .instruction(instruction), .op(op),
        .vj(vj), .vk(vk), .pc(pc), .imm(imm), .entry(entry)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: a list of occupied slots with pending-operand flags.
    typedef struct {
        logic          used;
        logic [5:0]    op;
        logic [31:0]   inst, pc, imm;
        logic [TW-1:0] entry;
        logic          pj;
        logic [TW-1:0] tj;
        logic [31:0]   vj;
        logic          pk;
        logic [TW-1:0] tk;
        logic [31:0]   vk;
    } mslot_t;

    mslot_t        m [RS];
    logic          e_nc;
    logic [31:0]   e_inst, e_vj, e_vk, e_pc, e_imm;
    logic [5:0]    e_op;
    logic [TW-1:0] e_entry;
    bit            known = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_full();
        int n = 0;
        for (int i = 0; i < RS; i++) if (m[i].used) n++;
        return n == RS;
    endfunction

    // Pending operand resolution against the buses; the ALU bus wins a tie.
    function automatic logic [32:0] cdb(input logic p, input logic [TW-1:0] t, input logic [31:0] v);
        if (p && alu_broadcast && alu_entry == t) return {1'b0, alu_result};
        if (p && lsb_broadcast && lsb_entry == t) return {1'b0, lsb_result};
        return {p, v};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < RS; i++) m[i].used = 1'b0;
    endtask

    task automatic model_update();
        mslot_t nxt [RS];
        int     iss = -1;
        int     slot = -1;
        if (rst_in) begin
            model_clear();
            e_nc = 0; e_inst = 0; e_op = 0; e_vj = 0; e_vk = 0; e_pc = 0; e_imm = 0; e_entry = 0;
            return;
        end
        if (!rdy_in) begin
            e_nc = 0;
            return;
        end
        if (flush) begin
            model_clear();
            e_nc = 0;
            return;
        end
        nxt = m;
        for (int i = 0; i < RS; i++)
            if (iss < 0 && m[i].used && !m[i].pj && !m[i].pk) iss = i;
        e_nc = (iss >= 0);
        if (iss >= 0) begin
            e_inst = m[iss].inst; e_op = m[iss].op; e_vj = m[iss].vj; e_vk = m[iss].vk;
            e_pc = m[iss].pc; e_imm = m[iss].imm; e_entry = m[iss].entry;
            nxt[iss].used = 1'b0;
        end
        for (int i = 0; i < RS; i++) begin
            if (m[i].used) begin
                {nxt[i].pj, nxt[i].vj} = cdb(m[i].pj, m[i].tj, m[i].vj);
                {nxt[i].pk, nxt[i].vk} = cdb(m[i].pk, m[i].tk, m[i].vk);
            end
        end
        for (int i = 0; i < RS; i++)
            if (slot < 0 && !m[i].used) slot = i;
        if (dispatch_valid && slot >= 0) begin
            nxt[slot].used  = 1'b1;
            nxt[slot].op    = dispatch_op;
            nxt[slot].inst  = dispatch_inst;
            nxt[slot].pc    = dispatch_pc;
            nxt[slot].imm   = dispatch_imm;
            nxt[slot].entry = dispatch_entry;
            nxt[slot].tj    = dispatch_qj;
            nxt[slot].tk    = dispatch_qk;
            {nxt[slot].pj, nxt[slot].vj} = cdb(dispatch_qj_busy, dispatch_qj, dispatch_vj);
            {nxt[slot].pk, nxt[slot].vk} = cdb(dispatch_qk_busy, dispatch_qk, dispatch_vk);
        end
        m = nxt;
    endtask

    // One clock: check rs_full before the edge, then all registered outputs after it.
    task automatic step();
        if (known) check("rs_full", 32'(rs_full), 32'(model_full()));
        model_update();
        @(posedge clk_in);
        #1;
        known = 1'b1;
        check("new_calculate", 32'(new_calculate), 32'(e_nc));
        check("instruction", instruction, e_inst);
        check("op", 32'(op), 32'(e_op));
        check("vj", vj, e_vj);
        check("vk", vk, e_vk);
        check("pc", pc, e_pc);
        check("imm", imm, e_imm);
        check("entry", 32'(entry), 32'(e_entry));
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1; flush = 0;
        dispatch_valid = 0; alu_broadcast = 0; lsb_broadcast = 0;
    endtask

    task automatic disp(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [TW-1:0] en,
                        input logic bj, input logic [TW-1:0] tj,
                        input logic bk, input logic [TW-1:0] tk);
        dispatch_valid = 1; dispatch_op = o; dispatch_vj = a; dispatch_vk = b;
        dispatch_imm = im; dispatch_entry = en; dispatch_qj_busy = bj; dispatch_qj = tj;
        dispatch_qk_busy = bk; dispatch_qk = tk;
        dispatch_inst = $urandom; dispatch_pc = $urandom;
    endtask

    initial begin
        for (int i = 0; i < RS; i++) m[i] = '{default: '0};
        e_nc = 0; e_inst = 0; e_op = 0; e_vj = 0; e_vk = 0; e_pc = 0; e_imm = 0; e_entry = 0;
        idle();
        dispatch_op = 0; dispatch_inst = 0; dispatch_pc = 0; dispatch_imm = 0; dispatch_entry = 0;
        dispatch_qj_busy = 0; dispatch_qj = 0; dispatch_vj = 0;
        dispatch_qk_busy = 0; dispatch_qk = 0; dispatch_vk = 0;
        alu_entry = 0; alu_result = 0; lsb_entry = 0; lsb_result = 0;

        // Reset
        rst_in = 1;
        step();
        check("reset_rs_full", 32'(rs_full), 32'd0);

        // Ready dispatch issues on the next edge for exactly one cycle
        idle(); disp(6'h13, 32'd5, 32'd0, 32'd3, 4'd2, 0, 4'd0, 0, 4'd0);
        step();
        check("ready_no_issue_at_dispatch", 32'(new_calculate), 32'd0);
        idle(); step();
        check("ready_nc", 32'(new_calculate), 32'd1);
        check("ready_op", 32'(op), 32'h13);
        check("ready_vj", vj, 32'd5);
        check("ready_imm", imm, 32'd3);
        check("ready_entry", 32'(entry), 32'd2);
        step();
        check("ready_single_pulse", 32'(new_calculate), 32'd0);

        // Wakeup through the ALU bus
        disp(6'h33, 32'd0, 32'd4, 32'd0, 4'd1, 1, 4'd7, 0, 4'd0);
        step();
        idle(); step(); step();
        check("wake_waiting", 32'(new_calculate), 32'd0);
        alu_broadcast = 1; alu_entry = 4'd7; alu_result = 32'd10;
        step();
        check("wake_not_at_capture", 32'(new_calculate), 32'd0);
        idle(); step();
        check("wake_nc", 32'(new_calculate), 32'd1);
        check("wake_vj", vj, 32'd10);
        check("wake_vk", vk, 32'd4);

        // Same-cycle capture from the LSB bus
        disp(6'h33, 32'd0, 32'd1, 32'd0, 4'd4, 1, 4'd3, 0, 4'd0);
        lsb_broadcast = 1; lsb_entry = 4'd3; lsb_result = 32'hFFFF_FFFF;
        step();
        idle(); step();
        check("samecyc_nc", 32'(new_calculate), 32'd1);
        check("samecyc_vj", vj, 32'hFFFF_FFFF);

        // Fill all slots on tag 9, ninth dispatch dropped, then drain in order
        for (int i = 0; i < RS; i++) begin
            disp(6'h01, 32'd0, 32'(i), 32'd0, TW'(i), 1, 4'd9, 0, 4'd0);
            step();
        end
        check("fill_full", 32'(rs_full), 32'd1);
        disp(6'h02, 32'd0, 32'd0, 32'd0, 4'd8, 0, 4'd0, 0, 4'd0);
        step();
        idle(); alu_broadcast = 1; alu_entry = 4'd9; alu_result = 32'h99;
        step();
        check("fill_full_after_capture", 32'(rs_full), 32'd1);
        idle();
        for (int i = 0; i < RS; i++) begin
            step();
            check("drain_nc", 32'(new_calculate), 32'd1);
            check("drain_entry", 32'(entry), 32'(i));
            check("drain_vk", vk, 32'(i));
            if (i == 0) check("drain_full_falls", 32'(rs_full), 32'd0);
        end
        step();
        check("drain_done", 32'(new_calculate), 32'd0);

        // Stall holds three READY slots, then flush empties them
        for (int i = 0; i < 3; i++) begin
            disp(6'h05, 32'd0, 32'd0, 32'd0, TW'(i), 1, 4'd5, 0, 4'd0);
            step();
        end
        idle(); alu_broadcast = 1; alu_entry = 4'd5; alu_result = 32'h55;
        step();
        for (int i = 0; i < 2; i++) begin
            idle(); rdy_in = 0;
            disp(6'h06, 32'd1, 32'd1, 32'd1, 4'd9, 0, 4'd0, 0, 4'd0);
            lsb_broadcast = 1; lsb_entry = 4'd5;
            step();
            check("stall_no_issue", 32'(new_calculate), 32'd0);
        end
        idle(); flush = 1;
        disp(6'h07, 32'd1, 32'd1, 32'd1, 4'd9, 0, 4'd0, 0, 4'd0);
        step();
        check("flush_nc", 32'(new_calculate), 32'd0);
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_empty", 32'(new_calculate), 32'd0);
        end

        // Reset with occupied slots and a concurrent dispatch
        for (int i = 0; i < 4; i++) begin
            disp(6'h08, 32'd0, 32'd0, 32'd0, TW'(i), 1, 4'd6, 0, 4'd0);
            step();
        end
        idle(); rst_in = 1; flush = 1;
        disp(6'h09, 32'd7, 32'd7, 32'd7, 4'd3, 0, 4'd0, 0, 4'd0);
        step();
        check("rst_nc", 32'(new_calculate), 32'd0);
        check("rst_vj", vj, 32'd0);
        check("rst_entry", 32'(entry), 32'd0);
        check("rst_full", 32'(rs_full), 32'd0);
        idle(); step();
        check("rst_no_issue_after", 32'(new_calculate), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_in           = ($urandom_range(0, 199) == 0);
            rdy_in           = ($urandom_range(0, 7) != 0);
            flush            = ($urandom_range(0, 39) == 0);
            dispatch_valid   = ($urandom_range(0, 9) < 6);
            dispatch_op      = 6'($urandom);
            dispatch_inst    = $urandom;
            dispatch_pc      = $urandom;
            dispatch_imm     = $urandom;
            dispatch_entry   = TW'($urandom);
            dispatch_qj_busy = $urandom_range(0, 1) == 1;
            dispatch_qj      = TW'($urandom_range(0, 3));
            dispatch_vj      = $urandom;
            dispatch_qk_busy = $urandom_range(0, 1) == 1;
            dispatch_qk      = TW'($urandom_range(0, 3));
            dispatch_vk      = $urandom;
            alu_broadcast    = ($urandom_range(0, 9) < 4);
            alu_entry        = TW'($urandom_range(0, 3));
            alu_result       = $urandom;
            lsb_broadcast    = ($urandom_range(0, 9) < 4);
            lsb_entry        = TW'($urandom_range(0, 3));
            lsb_result       = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
